pe_mem_adapter: RTL and testbench
=================================

PE_MEM_ADAPTER -- requirements
Module: pe_mem_adapter

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 32, as the width of the PE and memory address.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, as the width of the PE and memory data.
REQ-003 aclk  in  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 pe_address0  in  ADDR_WIDTH  PE access address.
REQ-006 pe_ce0  in  1  PE access enable.
REQ-007 pe_we0  in  1  PE write enable; qualified by pe_ce0.
REQ-008 pe_d0  in  DATA_WIDTH  PE write data.
REQ-009 pe_q0  out  DATA_WIDTH  read data returned to the PE.
REQ-010 pe_valid0  out  1  one-cycle completion pulse for the accepted access.
REQ-011 memory_stall  out  1  high while an access is in progress; the PE holds its inputs while it is high.
REQ-012 mem_req_valid, mem_req_ready  out, in  1 each  request handshake to the backing memory.
REQ-013 mem_req_addr, mem_req_we, mem_req_wdata  out  ADDR_WIDTH, 1, DATA_WIDTH  request payload.
REQ-014 mem_rsp_valid, mem_rsp_data  in  1, DATA_WIDTH  read response; no backpressure.
REQ-015 hit_cnt, miss_cnt  out  32 each  read hit and read miss counters.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ and WAIT_RSP; memory_stall SHALL be registered and equal to (state != IDLE).
REQ-017 The block SHALL keep a one-entry hold register: hold_valid, hold_addr and hold_data.
REQ-018 In IDLE, a read hit (pe_ce0=1, pe_we0=0, hold_valid=1, pe_address0==hold_addr) SHALL, on the next cycle, drive pe_q0=hold_data, pulse pe_valid0, keep memory_stall low and increment hit_cnt.
REQ-019 In IDLE, a read miss SHALL latch the address, enter REQ and increment miss_cnt.
REQ-020 In IDLE, a write SHALL latch address and data and enter REQ.
REQ-021 A write whose address equals hold_addr while hold_valid=1 SHALL update hold_data to pe_d0 (write-through).
REQ-022 In REQ, mem_req_valid SHALL be 1 with a stable payload until mem_req_ready=1.
REQ-023 On the REQ handshake of a write, the FSM SHALL go to IDLE and pulse pe_valid0 on the next cycle.
REQ-024 On the REQ handshake of a read, the FSM SHALL go to WAIT_RSP.
REQ-025 In WAIT_RSP, mem_rsp_valid=1 SHALL load pe_q0, hold_data and hold_addr, set hold_valid, pulse pe_valid0 on the next cycle and return the FSM to IDLE.
REQ-026 Latency SHALL be: hit, pe_ce0 at cycle N gives pe_valid0 at N+1; miss with ready at N+1 and response at K gives pe_valid0 at K+1, with memory_stall high from N+1 to K inclusive.
REQ-027 pe_ce0 SHALL be ignored outside IDLE.
REQ-028 mem_rsp_valid SHALL be ignored outside WAIT_RSP.
REQ-029 pe_valid0 SHALL never be high for two consecutive cycles from one access.
REQ-030 pe_q0 SHALL hold its value until the next read completion.
REQ-031 hit_cnt and miss_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Writes SHALL change neither hit_cnt nor miss_cnt.

Reset
REQ-033 aresetn=0 SHALL immediately set: state=IDLE; pe_q0, pe_valid0, memory_stall, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, hit_cnt and miss_cnt to 0; hold_valid=0.
REQ-034 A reset asserted in REQ or WAIT_RSP SHALL abandon the access, drop mem_req_valid without a handshake, and discard any later response.
REQ-035 The first access after reset SHALL always be a miss.

Verification
REQ-036 Read 0x10 after reset, ready=1 immediately, response 0x1 three cycles later -> stall high 4 cycles, pe_q0=0x1 with valid pulse, miss_cnt=1.
REQ-037 Repeat read 0x10 -> valid at N+1, pe_q0=0x1, stall never high, hit_cnt=1.
REQ-038 Write 0x10 with data 0xAB, ready held low 5 cycles -> mem_req_valid and payload stable 5 cycles, valid pulse after handshake; following read 0x10 hits and returns 0xAB.
REQ-039 Read 0x20 while mem_rsp_valid is pulsed spuriously in IDLE and during REQ -> pulses ignored; only the WAIT_RSP response is returned.
REQ-040 Assert reset during WAIT_RSP, then deliver a response -> all outputs 0, no valid pulse, next read of the same address misses.
REQ-041 Preload miss_cnt to 32'hFFFF_FFFF via force, then perform a miss -> miss_cnt stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pe_mem_adapter.sv
// Adapter between a PE scratchpad-style port and a valid/ready backing memory,
// with a one-entry read-hold register that serves repeat reads without a memory trip.
module pe_mem_adapter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] pe_address0,
  input  logic                  pe_ce0,
  input  logic                  pe_we0,
  input  logic [DATA_WIDTH-1:0] pe_d0,
  output logic [DATA_WIDTH-1:0] pe_q0,
  output logic                  pe_valid0,
  output logic                  memory_stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pe_q0_q, pe_q0_d;
  logic                  pe_valid0_q, pe_valid0_d;
  logic                  stall_q, stall_d;
  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_we_q, req_we_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  logic hold_match;
  assign hold_match = hold_valid_q && (pe_address0 == hold_addr_q);

  always_comb begin
    state_d      = state_q;
    pe_q0_d      = pe_q0_q;
    pe_valid0_d  = 1'b0;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;

    unique case (state_q)
      IDLE: begin
        if (pe_ce0) begin
          if (pe_we0) begin
            req_valid_d = 1'b1;
            req_addr_d  = pe_address0;
            req_we_d    = 1'b1;
            req_wdata_d = pe_d0;
            state_d     = REQ;
            // Write-through keeps the hold entry coherent with memory.
            if (hold_match) hold_data_d = pe_d0;
          end else if (hold_match) begin
            pe_q0_d     = hold_data_q;
            pe_valid0_d = 1'b1;
            hit_cnt_d   = (hit_cnt_q != '1) ? hit_cnt_q + 32'd1 : hit_cnt_q;
          end else begin
            req_valid_d = 1'b1;
            req_addr_d  = pe_address0;
            req_we_d    = 1'b0;
            state_d     = REQ;
            miss_cnt_d  = (miss_cnt_q != '1) ? miss_cnt_q + 32'd1 : miss_cnt_q;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          if (req_we_q) begin
            pe_valid0_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          pe_q0_d      = mem_rsp_data;
          pe_valid0_d  = 1'b1;
          hold_valid_d = 1'b1;
          hold_addr_d  = req_addr_q;
          hold_data_d  = mem_rsp_data;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      pe_q0_q      <= '0;
      pe_valid0_q  <= 1'b0;
      stall_q      <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      pe_q0_q      <= pe_q0_d;
      pe_valid0_q  <= pe_valid0_d;
      stall_q      <= stall_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_we_q     <= req_we_d;
      req_wdata_q  <= req_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign pe_q0         = pe_q0_q;
  assign pe_valid0     = pe_valid0_q;
  assign memory_stall  = stall_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_wdata = req_wdata_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_pe_mem_adapter.sv
// Scoreboard bench for pe_mem_adapter: stimulus queues expected pe_q0 values,
// a negedge monitor pops one per pe_valid0 pulse.
module tb_pe_mem_adapter;

  logic        aclk;
  logic        aresetn;
  logic [31:0] pe_address0;
  logic        pe_ce0;
  logic        pe_we0;
  logic [31:0] pe_d0;
  logic [31:0] pe_q0;
  logic        pe_valid0;
  logic        memory_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;

  pe_mem_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .pe_address0(pe_address0), .pe_ce0(pe_ce0), .pe_we0(pe_we0), .pe_d0(pe_d0),
    .pe_q0(pe_q0), .pe_valid0(pe_valid0), .memory_stall(memory_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge aclk) begin
    if (pe_valid0 === 1'b1) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_twice: got 2 consecutive pulses expected 1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got pulse q=%0h expected none", pe_q0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pe_q0 !== e) begin
          errors++;
          $display("FAIL pe_q0: got %0h expected %0h", pe_q0, e);
        end
      end
    end
    prev_valid = (pe_valid0 === 1'b1);
  end

  task automatic read_miss(input logic [31:0] a, input logic [31:0] rd, input int rsp_at,
                           output int stall_cycles);
    stall_cycles = 0;
    @(negedge aclk);
    pe_address0 = a; pe_we0 = 1'b0; pe_ce0 = 1'b1;
    exp_q.push_back(rd);
    for (int i = 1; i <= rsp_at + 3; i++) begin
      @(negedge aclk);
      pe_ce0 = 1'b0;
      mem_rsp_valid = 1'b0;
      if (memory_stall) stall_cycles++;
      if (i == 1) begin
        check("miss_req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("miss_req_addr", {32'd0, mem_req_addr}, {32'd0, a});
        check("miss_req_we", {63'd0, mem_req_we}, 64'd0);
      end
      if (i == rsp_at) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rd;
      end
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [31:0] rd);
    @(negedge aclk);
    pe_address0 = a; pe_we0 = 1'b0; pe_ce0 = 1'b1;
    exp_q.push_back(rd);
    @(negedge aclk);
    pe_ce0 = 1'b0;
    check("hit_stall", {63'd0, memory_stall}, 64'd0);
    check("hit_valid", {63'd0, pe_valid0}, 64'd1);
    @(negedge aclk);
  endtask

  initial begin
    int sc;
    aresetn = 1'b0;
    pe_address0 = '0; pe_ce0 = 1'b0; pe_we0 = 1'b0; pe_d0 = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #1;
    check("rst_q", {32'd0, pe_q0}, 64'd0);
    check("rst_flags", {60'd0, pe_valid0, memory_stall, mem_req_valid, mem_req_we}, 64'd0);
    check("rst_addr", {32'd0, mem_req_addr}, 64'd0);
    check("rst_wdata", {32'd0, mem_req_wdata}, 64'd0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // First read after reset misses; stall spans request plus response wait.
    read_miss(32'h10, 32'h1, 4, sc);
    check("miss_stall_cycles", 64'(sc), 64'd4);
    check("miss_cnt_1", {32'd0, miss_cnt}, 64'd1);
    check("hit_cnt_0", {32'd0, hit_cnt}, 64'd0);

    read_hit(32'h10, 32'h1);
    check("hit_cnt_1", {32'd0, hit_cnt}, 64'd1);

    // Write with ready held low: payload must stay put, pe_q0 keeps last read data.
    mem_req_ready = 1'b0;
    @(negedge aclk);
    pe_address0 = 32'h10; pe_we0 = 1'b1; pe_d0 = 32'hAB; pe_ce0 = 1'b1;
    exp_q.push_back(32'h1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge aclk);
      pe_ce0 = 1'b0; pe_we0 = 1'b0;
      check("wr_valid_we", {62'd0, mem_req_valid, mem_req_we}, 64'd3);
      check("wr_addr", {32'd0, mem_req_addr}, 64'h10);
      check("wr_wdata", {32'd0, mem_req_wdata}, 64'hAB);
      check("wr_stall", {63'd0, memory_stall}, 64'd1);
      if (i == 5) mem_req_ready = 1'b1;
    end
    @(negedge aclk);
    check("wr_done_stall", {63'd0, memory_stall}, 64'd0);
    check("wr_done_reqv", {63'd0, mem_req_valid}, 64'd0);
    @(negedge aclk);
    read_hit(32'h10, 32'hAB);
    check("cnts_after_wr", {hit_cnt, miss_cnt}, {32'd2, 32'd1});

    // Spurious responses in IDLE and REQ are dropped.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD;
    @(negedge aclk);
    mem_rsp_valid = 1'b0;
    @(negedge aclk);
    check("idle_spur_q", {32'd0, pe_q0}, 64'hAB);
    mem_req_ready = 1'b0;
    pe_address0 = 32'h20; pe_we0 = 1'b0; pe_ce0 = 1'b1;
    exp_q.push_back(32'h22);
    @(negedge aclk);
    pe_ce0 = 1'b0;
    check("req_spur_stall", {62'd0, memory_stall, mem_req_valid}, 64'd3);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD;
    @(negedge aclk);
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge aclk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h22;
    @(negedge aclk);
    mem_rsp_valid = 1'b0;
    @(negedge aclk);
    check("cnts_after_spur", {hit_cnt, miss_cnt}, {32'd2, 32'd2});

    // Reset mid-access in WAIT_RSP, then a stale response arrives.
    pe_address0 = 32'h30; pe_we0 = 1'b0; pe_ce0 = 1'b1;
    @(negedge aclk);
    pe_ce0 = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("mid_rst_flags", {60'd0, pe_valid0, memory_stall, mem_req_valid, mem_req_we}, 64'd0);
    check("mid_rst_q", {32'd0, pe_q0}, 64'd0);
    check("mid_rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
    @(negedge aclk);
    mem_rsp_valid = 1'b0;
    repeat (3) @(negedge aclk);
    check("post_rst_q", {32'd0, pe_q0}, 64'd0);
    check("post_rst_stall", {63'd0, memory_stall}, 64'd0);
    read_miss(32'h30, 32'h33, 4, sc);
    check("post_rst_miss_stall", 64'(sc), 64'd4);
    check("post_rst_miss_cnt", {32'd0, miss_cnt}, 64'd1);

    // Saturation of the miss counter.
    @(negedge aclk);
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    read_miss(32'h40, 32'h44, 4, sc);
    check("miss_cnt_sat", {32'd0, miss_cnt}, 64'hFFFF_FFFF);
    check("hit_cnt_sat_run", {32'd0, hit_cnt}, 64'd0);

    repeat (3) @(negedge aclk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
